// File: rtl/fetch_dispatch_pkg.sv
// Shared sizes, opcode/fun7 constants and the issue-class enum for fetch_dispatch.
package fetch_dispatch_pkg;

    localparam int ROB_DEPTH  = 8;
    localparam int TAG_W      = 3;
    localparam int PC_W       = 7;
    localparam int IMEM_DEPTH = 128;
    localparam int CNT_W      = 4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ADD  = 2'd1,
        MUL  = 2'd2,
        LOAD = 2'd3
    } inst_class_e;

endpackage

// File: rtl/fetch_unit.sv
// Program memory, PC and fetched-instruction register; hold freezes pc/inst/inst_v.
module fetch_unit
    import fetch_dispatch_pkg::*;
(
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            imem_we,
    input  logic [PC_W-1:0] imem_waddr,
    input  logic [31:0]     imem_wdata,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     inst,
    output logic            inst_v
);

    logic [31:0] imem [IMEM_DEPTH];

    // Program load is independent of reset so a program can be written while held in reset.
    always_ff @(posedge clk1) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            pc     <= '0;
            inst   <= '0;
            inst_v <= 1'b0;
        end else if (!hold) begin
            inst   <= imem[pc];
            inst_v <= 1'b1;
            pc     <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_dispatch.sv
// In-order fetch/decode/issue with ROB tag allocation and register rename table.
// Optional mul class issue is enabled by defining FETCH_DISPATCH_MUL_EN.
module fetch_dispatch
    import fetch_dispatch_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              imem_we,
    input  logic [PC_W-1:0]   imem_waddr,
    input  logic [31:0]       imem_wdata,
    input  logic              rs_add_free,
    input  logic              rs_mul_free,
    input  logic              rs_load_free,
    input  logic              rob_commit,
    input  logic [4:0]        rob_commit_dest,
    input  logic [TAG_W-1:0]  rob_commit_tag,
    output logic [PC_W-1:0]   pc,
    output logic [31:0]       inst,
    output logic              stall,
    output logic              disp_add_v,
    output logic              disp_mul_v,
    output logic              disp_load_v,
    output logic [6:0]        disp_fun7,
    output logic [2:0]        disp_fun3,
    output logic [4:0]        disp_rd,
    output logic [4:0]        disp_rs1,
    output logic [4:0]        disp_rs2,
    output logic [11:0]       disp_offset,
    output logic [TAG_W-1:0]  disp_rob_tag,
    output logic              disp_src1_busy,
    output logic [TAG_W-1:0]  disp_src1_tag,
    output logic              disp_src2_busy,
    output logic [TAG_W-1:0]  disp_src2_tag
);

    logic inst_v;

    fetch_unit u_fetch (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .hold       (stall),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .pc         (pc),
        .inst       (inst),
        .inst_v     (inst_v)
    );

    logic [6:0]  fun7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  fun3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [11:0] offset;

    assign fun7   = inst[31:25];
    assign rs2    = inst[24:20];
    assign rs1    = inst[19:15];
    assign fun3   = inst[14:12];
    assign rd     = inst[11:7];
    assign opcode = inst[6:0];
    assign offset = inst[31:20];

    inst_class_e cls;
    logic        class_free;

`ifndef FETCH_DISPATCH_MUL_EN
    logic mul_free_unused;
    assign mul_free_unused = rs_mul_free;
`endif

    always_comb begin
        cls        = NONE;
        class_free = 1'b0;
        if (opcode == OP_R) begin
            if (fun7 == F7_ADD || fun7 == F7_SUB) begin
                cls = ADD;
            end
`ifdef FETCH_DISPATCH_MUL_EN
            else if (fun7 == F7_MUL) begin
                cls = MUL;
            end
`endif
        end else if (opcode == OP_LOAD) begin
            cls = LOAD;
        end
        case (cls)
            ADD:     class_free = rs_add_free;
`ifdef FETCH_DISPATCH_MUL_EN
            MUL:     class_free = rs_mul_free;
`endif
            LOAD:    class_free = rs_load_free;
            default: class_free = 1'b0;
        endcase
    end

    logic [CNT_W-1:0] rob_count;
    logic [TAG_W-1:0] rob_tail;
    logic             commit_ok;
    logic             issue;

    assign commit_ok = rob_commit && (rob_count != '0);
    assign issue     = inst_v && (cls != NONE) && class_free && (rob_count < CNT_W'(ROB_DEPTH));
    assign stall     = inst_v && (cls != NONE) && !issue;

    logic [31:0]      busy;
    logic [TAG_W-1:0] tag_tbl [32];

    logic             src1_busy;
    logic [TAG_W-1:0] src1_tag;
    logic             src2_busy;
    logic [TAG_W-1:0] src2_tag;

    // A commit retiring exactly the producer being looked up makes the source ready now.
    always_comb begin
        src1_tag  = tag_tbl[rs1];
        src1_busy = (rs1 != '0) && busy[rs1]
                    && !(commit_ok && rob_commit_dest == rs1 && rob_commit_tag == src1_tag);
        src2_tag  = tag_tbl[rs2];
        src2_busy = (rs2 != '0) && busy[rs2]
                    && !(commit_ok && rob_commit_dest == rs2 && rob_commit_tag == src2_tag);
        if (cls == LOAD) begin
            src2_tag  = '0;
            src2_busy = 1'b0;
        end
    end

    logic issue_writes_rd;
    assign issue_writes_rd = issue && (rd != '0);

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (commit_ok && tag_tbl[rob_commit_dest] == rob_commit_tag
                && !(issue_writes_rd && rd == rob_commit_dest)) begin
                busy[rob_commit_dest] <= 1'b0;
            end
            if (issue_writes_rd) begin
                busy[rd] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst_n && issue_writes_rd) begin
            tag_tbl[rd] <= rob_tail;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            rob_tail  <= '0;
            rob_count <= '0;
        end else begin
            if (issue) begin
                rob_tail <= rob_tail + 1'b1;
            end
            case ({issue, commit_ok})
                2'b10:   rob_count <= rob_count + 1'b1;
                2'b01:   rob_count <= rob_count - 1'b1;
                default: rob_count <= rob_count;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            disp_add_v     <= 1'b0;
            disp_load_v    <= 1'b0;
            disp_fun7      <= '0;
            disp_fun3      <= '0;
            disp_rd        <= '0;
            disp_rs1       <= '0;
            disp_rs2       <= '0;
            disp_offset    <= '0;
            disp_rob_tag   <= '0;
            disp_src1_busy <= 1'b0;
            disp_src1_tag  <= '0;
            disp_src2_busy <= 1'b0;
            disp_src2_tag  <= '0;
        end else begin
            disp_add_v  <= issue && (cls == ADD);
            disp_load_v <= issue && (cls == LOAD);
            if (issue) begin
                disp_fun7      <= fun7;
                disp_fun3      <= fun3;
                disp_rd        <= rd;
                disp_rs1       <= rs1;
                disp_rs2       <= rs2;
                disp_offset    <= offset;
                disp_rob_tag   <= rob_tail;
                disp_src1_busy <= src1_busy;
                disp_src1_tag  <= src1_tag;
                disp_src2_busy <= src2_busy;
                disp_src2_tag  <= src2_tag;
            end
        end
    end

`ifdef FETCH_DISPATCH_MUL_EN
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            disp_mul_v <= 1'b0;
        end else begin
            disp_mul_v <= issue && (cls == MUL);
        end
    end
`else
    assign disp_mul_v = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_dispatch.sv
// Scoreboard bench for fetch_dispatch: directed program scenarios plus randomized streams.
module tb_fetch_dispatch;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_we = 1'b0;
    logic [6:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        rs_add_free = 1'b1;
    logic        rs_mul_free = 1'b1;
    logic        rs_load_free = 1'b1;
    logic        rob_commit = 1'b0;
    logic [4:0]  rob_commit_dest = '0;
    logic [2:0]  rob_commit_tag = '0;
    logic [6:0]  pc;
    logic [31:0] inst;
    logic        stall;
    logic        disp_add_v, disp_mul_v, disp_load_v;
    logic [6:0]  disp_fun7;
    logic [2:0]  disp_fun3;
    logic [4:0]  disp_rd, disp_rs1, disp_rs2;
    logic [11:0] disp_offset;
    logic [2:0]  disp_rob_tag;
    logic        disp_src1_busy, disp_src2_busy;
    logic [2:0]  disp_src1_tag, disp_src2_tag;

    always #5 clk1 = ~clk1;

    fetch_dispatch dut (
        .clk1(clk1), .rst_n(rst_n),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .rs_add_free(rs_add_free), .rs_mul_free(rs_mul_free), .rs_load_free(rs_load_free),
        .rob_commit(rob_commit), .rob_commit_dest(rob_commit_dest), .rob_commit_tag(rob_commit_tag),
        .pc(pc), .inst(inst), .stall(stall),
        .disp_add_v(disp_add_v), .disp_mul_v(disp_mul_v), .disp_load_v(disp_load_v),
        .disp_fun7(disp_fun7), .disp_fun3(disp_fun3), .disp_rd(disp_rd),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_offset(disp_offset),
        .disp_rob_tag(disp_rob_tag),
        .disp_src1_busy(disp_src1_busy), .disp_src1_tag(disp_src1_tag),
        .disp_src2_busy(disp_src2_busy), .disp_src2_tag(disp_src2_tag)
    );

    typedef struct {
        int         cyc;
        int         cls;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        logic [11:0] off;
        logic [2:0] tag;
        logic       b1;
        logic [2:0] t1;
        logic       b2;
        logic [2:0] t2;
    } exp_t;

    typedef struct {
        logic [2:0] tag;
        logic [4:0] dest;
    } rob_t;

    exp_t        sbq[$];
    rob_t        rob_q[$];
    logic [31:0] m_mem [128];
    int          m_pc;
    logic [31:0] m_inst;
    logic        m_iv;
    logic        m_busy [32];
    logic [2:0]  m_tag [32];
    int          m_tail;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // 0 = dropped, 1 = add, 2 = mul, 3 = load
    function automatic int cls_of(input logic [31:0] i);
        if (i[6:0] == 7'h33) begin
            if (i[31:25] == 7'h00 || i[31:25] == 7'h20) return 1;
`ifdef FETCH_DISPATCH_MUL_EN
            if (i[31:25] == 7'h01) return 2;
`endif
            return 0;
        end
        if (i[6:0] == 7'h03) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2,
                                           input logic [4:0] s1, input logic [4:0] d);
        return {f7, s2, s1, 3'b000, d, 7'h33};
    endfunction

    function automatic logic [31:0] ld(input logic [11:0] off, input logic [4:0] s1,
                                       input logic [4:0] d);
        return {off, s1, 3'b010, d, 7'h03};
    endfunction

    function automatic logic src_busy(input logic [4:0] r, input logic cok,
                                      input logic [4:0] cd, input logic [2:0] ct);
        if (r == 0 || !m_busy[r]) return 1'b0;
        return !(cok && cd == r && ct == m_tag[r]);
    endfunction

    // One clock of stimulus: drive inputs, check fetch/stall against the model, predict issue.
    task automatic step(input logic r, input logic fa, input logic fm, input logic fl,
                        input logic c, input logic [4:0] cd, input logic [2:0] ct,
                        input logic we, input logic [6:0] wa, input logic [31:0] wd);
        int   k;
        logic free_ok, cok, iss;
        exp_t e;
        rob_t re;
        @(negedge clk1);
        rst_n = r; rs_add_free = fa; rs_mul_free = fm; rs_load_free = fl;
        rob_commit = c; rob_commit_dest = cd; rob_commit_tag = ct;
        imem_we = we; imem_waddr = wa; imem_wdata = wd;
        #1;
        if (!r) begin
            m_pc = 0; m_inst = '0; m_iv = 1'b0; m_tail = 0;
            rob_q.delete();
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            chk("pc", {25'd0, pc}, m_pc);
            chk("inst", inst, m_inst);
            k = m_iv ? cls_of(m_inst) : 0;
            free_ok = (k == 1) ? fa : (k == 2) ? fm : (k == 3) ? fl : 1'b0;
            cok = c && rob_q.size() > 0;
            iss = (k != 0) && free_ok && rob_q.size() < 8;
            chk("stall", stall, (k != 0) && !iss);
            if (iss) begin
                e.cyc = cyc + 1; e.cls = k;
                e.f7 = m_inst[31:25]; e.f3 = m_inst[14:12]; e.rd = m_inst[11:7];
                e.rs1 = m_inst[19:15]; e.rs2 = m_inst[24:20]; e.off = m_inst[31:20];
                e.tag = m_tail[2:0];
                e.b1 = src_busy(e.rs1, cok, cd, ct); e.t1 = m_tag[e.rs1];
                e.b2 = (k == 3) ? 1'b0 : src_busy(e.rs2, cok, cd, ct); e.t2 = m_tag[e.rs2];
                sbq.push_back(e);
            end
            if (cok) begin
                void'(rob_q.pop_front());
                if (m_tag[cd] == ct && !(iss && m_inst[11:7] == cd && cd != 0)) m_busy[cd] = 1'b0;
            end
            if (iss) begin
                if (m_inst[11:7] != 0) begin
                    m_busy[m_inst[11:7]] = 1'b1;
                    m_tag[m_inst[11:7]]  = m_tail[2:0];
                end
                re.tag = m_tail[2:0]; re.dest = m_inst[11:7];
                rob_q.push_back(re);
                m_tail = (m_tail + 1) % 8;
            end
            if (!((k != 0) && !iss)) begin
                m_inst = m_mem[m_pc];
                m_iv = 1'b1;
                m_pc = (m_pc + 1) % 128;
            end
        end
        if (we) m_mem[wa] = wd;
    endtask

    task automatic load_prog(input logic [31:0] p[$]);
        for (int i = 0; i < 128; i++)
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 1'b1, i[6:0],
                 (i < p.size()) ? p[i] : 32'h0);
        @(posedge clk1); #2;
        chk("rst_add_v", disp_add_v, 0);
        chk("rst_load_v", disp_load_v, 0);
        chk("rst_rob_tag", disp_rob_tag, 0);
        chk("rst_rd", disp_rd, 0);
        chk("rst_offset", disp_offset, 0);
        chk("rst_src1_busy", disp_src1_busy, 0);
    endtask

    // pol: 0 all free; 2 random; 3 commit head when the current inst reads it; 4 stale x3 commit; 5 load blocked
    task automatic run(input int n, input int pol);
        logic       r, fa, fm, fl, c;
        logic [4:0] cd;
        logic [2:0] ct;
        logic [4:0] s1, s2;
        for (int i = 0; i < n; i++) begin
            r = 1'b1; fa = 1'b1; fm = 1'b1; fl = (pol != 5); c = 1'b0; cd = '0; ct = '0;
            s1 = m_inst[19:15]; s2 = m_inst[24:20];
            if (pol == 2) begin
                fa = ($urandom_range(0, 3) != 0);
                fm = ($urandom_range(0, 3) != 0);
                fl = ($urandom_range(0, 3) != 0);
                r  = ($urandom_range(0, 149) != 0);
                if (rob_q.size() > 0 && $urandom_range(0, 9) < 4) begin
                    c = 1'b1; cd = rob_q[0].dest; ct = rob_q[0].tag;
                    if ($urandom_range(0, 6) == 0) ct = 3'($urandom_range(0, 7));
                end
            end else if (pol == 3) begin
                if (m_iv && rob_q.size() > 0 && rob_q[0].dest != 0
                    && (s1 == rob_q[0].dest || s2 == rob_q[0].dest)) begin
                    c = 1'b1; cd = rob_q[0].dest; ct = rob_q[0].tag;
                end
            end else if (pol == 4) begin
                if (m_iv && rob_q.size() > 0 && s1 == 5'd3) begin
                    c = 1'b1; cd = 5'd3; ct = 3'd2;
                end
            end
            step(r, fa, fm, fl, c, cd, ct, 1'b0, 7'd0, 32'h0);
        end
    endtask

    // Monitor: every issue pulse must match the oldest expected issue for this cycle.
    initial begin
        exp_t e;
        int   got;
        forever begin
            @(posedge clk1); #1;
            chk("one_hot", 32'(disp_add_v) + 32'(disp_mul_v) + 32'(disp_load_v) <= 1, 1);
            got = disp_add_v ? 1 : disp_mul_v ? 2 : disp_load_v ? 3 : 0;
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                chk("issue_class", got, e.cls);
                chk("fun7", disp_fun7, e.f7);
                chk("fun3", disp_fun3, e.f3);
                chk("rd", disp_rd, e.rd);
                chk("rs1", disp_rs1, e.rs1);
                chk("rs2", disp_rs2, e.rs2);
                chk("offset", disp_offset, e.off);
                chk("rob_tag", disp_rob_tag, e.tag);
                chk("src1_busy", disp_src1_busy, e.b1);
                if (e.b1) chk("src1_tag", disp_src1_tag, e.t1);
                chk("src2_busy", disp_src2_busy, e.b2);
                if (e.b2) chk("src2_tag", disp_src2_tag, e.t2);
            end else begin
                chk("no_issue", got, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p[$];
        logic [31:0] w;
        int          sel;

        // sequential issue, then a dropped all-zero word
        p = '{32'h002081B3, 32'h0};
        load_prog(p);
        run(6, 0);

        // dependency on the previous add
        p = '{r_type(7'h00, 5'd2, 5'd1, 5'd3), r_type(7'h20, 5'd1, 5'd3, 5'd4)};
        load_prog(p);
        run(6, 0);

        // ROB full with nine adds, then one commit of the head
        p.delete();
        for (int i = 0; i < 9; i++) p.push_back(r_type(7'h00, 5'd2, 5'd1, 5'(10 + i)));
        load_prog(p);
        run(14, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, rob_q[0].dest, rob_q[0].tag, 1'b0, 7'd0, 32'h0);
        run(4, 0);

        // load station full, then released
        p = '{ld(12'd8, 5'd1, 5'd5)};
        load_prog(p);
        run(6, 5);
        run(4, 0);

        // same-cycle commit of the producer
        p = '{r_type(7'h00, 5'd2, 5'd1, 5'd3), 32'h0, r_type(7'h00, 5'd1, 5'd3, 5'd7)};
        load_prog(p);
        run(8, 3);

        // stale-tag commit leaves the source busy
        p = '{r_type(7'h00, 5'd2, 5'd1, 5'd3), r_type(7'h00, 5'd2, 5'd1, 5'd9),
              r_type(7'h00, 5'd2, 5'd1, 5'd10), r_type(7'h00, 5'd1, 5'd3, 5'd11)};
        load_prog(p);
        run(8, 4);

        // mul: issues only when the mul class is built in
        p = '{32'h02208333, r_type(7'h00, 5'd3, 5'd2, 5'd1)};
        load_prog(p);
        run(6, 0);

        // randomized streams
        for (int t = 0; t < 3; t++) begin
            p.delete();
            for (int i = 0; i < 128; i++) begin
                sel = $urandom_range(0, 9);
                if (sel < 4)
                    w = r_type(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                else if (sel < 6)
                    w = r_type(7'h01, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)));
                else if (sel < 8)
                    w = ld(12'($urandom_range(0, 4095)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)));
                else if (sel == 8)
                    w = 32'h0;
                else
                    w = $urandom;
                p.push_back(w);
            end
            load_prog(p);
            run(300, 2);
        end

        run(3, 0);
        @(posedge clk1); #3;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
